// File: rtl/vend_ctrl_multi.sv
// Multi-item vending controller: one credit accumulator, per-item price table,
// unit-by-unit change return, cancel/refund and an inactivity timeout.
module vend_ctrl_multi #(
    parameter int                           NUM_ITEMS   = 4,
    parameter int                           PRICE_W     = 4,
    parameter logic [NUM_ITEMS*PRICE_W-1:0] PRICE_TABLE = {4'd6, 4'd5, 4'd4, 4'd3},
    parameter int                           CREDIT_W    = 5,
    parameter int                           TIMEOUT_CYC = 1000
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUM_ITEMS-1:0]         item_sel,
    input  logic                         rs_5_in,
    input  logic                         rs_10_in,
    input  logic                         cancel,
    output logic                         coin_accept,
    output logic                         dispense,
    output logic [$clog2(NUM_ITEMS)-1:0] item_id,
    output logic                         rs_5_out,
    output logic [CREDIT_W-1:0]          credit,
    output logic                         sel_err
);
    localparam int ID_W  = $clog2(NUM_ITEMS);
    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);

    function automatic int max_price();
        int m;
        m = 0;
        for (int i = 0; i < NUM_ITEMS; i++) begin
            if (int'(PRICE_TABLE[i*PRICE_W +: PRICE_W]) > m)
                m = int'(PRICE_TABLE[i*PRICE_W +: PRICE_W]);
        end
        return m;
    endfunction

    localparam int MAX_PRICE = max_price();

    // Worst case credit is price-1 plus a simultaneous 5+10 coin pair.
    if (MAX_PRICE + 2 >= (1 << CREDIT_W)) begin : g_credit_w_check
        $error("CREDIT_W too narrow for the largest price in PRICE_TABLE");
    end

    typedef enum logic [2:0] {IDLE, COLLECT, DISPENSE, CHANGE, REFUND} state_t;

    state_t              state, state_nxt;
    logic [PRICE_W-1:0]  price, price_nxt;
    logic [ID_W-1:0]     idx, idx_nxt;
    logic [CREDIT_W-1:0] change, change_nxt;
    logic [TMR_W-1:0]    timer, timer_nxt;
    logic                phase, phase_nxt;

    logic [CREDIT_W-1:0] credit_nxt, coin_units, credit_add;
    logic [ID_W-1:0]     item_id_nxt, sel_idx;
    logic [PRICE_W-1:0]  sel_price;
    logic                dispense_nxt, rs_5_nxt, sel_err_nxt, coin_accept_nxt;
    logic                sel_onehot, coin_seen;

    always_comb begin
        sel_idx   = '0;
        sel_price = '0;
        for (int i = 0; i < NUM_ITEMS; i++) begin
            if (item_sel[i]) begin
                sel_idx   = ID_W'(i);
                sel_price = PRICE_TABLE[i*PRICE_W +: PRICE_W];
            end
        end
    end

    assign sel_onehot = (item_sel != '0) &&
                        ((item_sel & (item_sel - NUM_ITEMS'(1))) == '0);
    // {rs_10, rs_5} read as a binary number is exactly the units added.
    assign coin_units = CREDIT_W'({rs_10_in, rs_5_in});
    assign credit_add = credit + coin_units;
    assign coin_seen  = rs_5_in | rs_10_in;

    always_comb begin
        state_nxt    = state;
        price_nxt    = price;
        idx_nxt      = idx;
        change_nxt   = change;
        timer_nxt    = timer;
        phase_nxt    = phase;
        credit_nxt   = credit;
        dispense_nxt = 1'b0;
        rs_5_nxt     = 1'b0;
        sel_err_nxt  = 1'b0;

        case (state)
            IDLE: begin
                if (sel_onehot) begin
                    idx_nxt    = sel_idx;
                    price_nxt  = sel_price;
                    timer_nxt  = '0;
                    credit_nxt = '0;
                    state_nxt  = COLLECT;
                end else if (item_sel != '0) begin
                    sel_err_nxt = 1'b1;
                end
            end
            COLLECT: begin
                credit_nxt = credit_add;
                timer_nxt  = coin_seen ? '0 : timer + TMR_W'(1);
                if (cancel) begin
                    state_nxt = REFUND;
                end else if (credit_add >= CREDIT_W'(price)) begin
                    state_nxt    = DISPENSE;
                    dispense_nxt = 1'b1;
                end else if (!coin_seen && timer == TMR_W'(TIMEOUT_CYC - 1)) begin
                    state_nxt = REFUND;
                end
            end
            DISPENSE: begin
                change_nxt = credit - CREDIT_W'(price);
                credit_nxt = '0;
                phase_nxt  = 1'b0;
                state_nxt  = (credit == CREDIT_W'(price)) ? IDLE : CHANGE;
            end
            REFUND: begin
                change_nxt = credit;
                credit_nxt = '0;
                phase_nxt  = 1'b0;
                state_nxt  = (credit == '0) ? IDLE : CHANGE;
            end
            CHANGE: begin
                // phase 0 issues a unit pulse, phase 1 is the mandatory low gap.
                if (!phase) begin
                    if (change != '0) begin
                        rs_5_nxt   = 1'b1;
                        change_nxt = change - CREDIT_W'(1);
                        phase_nxt  = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    phase_nxt = 1'b0;
                    if (change == '0) state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        item_id_nxt     = dispense_nxt ? idx : '0;
        coin_accept_nxt = (state_nxt == COLLECT);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            price       <= '0;
            idx         <= '0;
            change      <= '0;
            timer       <= '0;
            phase       <= 1'b0;
            credit      <= '0;
            coin_accept <= 1'b0;
            dispense    <= 1'b0;
            item_id     <= '0;
            rs_5_out    <= 1'b0;
            sel_err     <= 1'b0;
        end else begin
            state       <= state_nxt;
            price       <= price_nxt;
            idx         <= idx_nxt;
            change      <= change_nxt;
            timer       <= timer_nxt;
            phase       <= phase_nxt;
            credit      <= credit_nxt;
            coin_accept <= coin_accept_nxt;
            dispense    <= dispense_nxt;
            item_id     <= item_id_nxt;
            rs_5_out    <= rs_5_nxt;
            sel_err     <= sel_err_nxt;
        end
    end
endmodule
